// File: rtl/display_pkg.sv
// Shared digit-word type, scan FSM states and seven-segment decode for the display path.
// Optional macro DISPLAY_HEX_DECODE_EN adds A..F glyphs for values 10..15.
package display_pkg;

    typedef struct packed {
        logic       en;
        logic [3:0] value;
        logic       dp;
    } digit_word_t;

    typedef enum logic {
        ST_BLANK,
        ST_SHOW
    } scan_state_t;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Returns {a,b,c,d,e,f,g}, active-low.
    function automatic logic [6:0] seg7_decode(input logic [3:0] value);
        logic [6:0] seg;
        seg = SEG_BLANK;
        case (value)
            4'd0:    seg = 7'b0000001;
            4'd1:    seg = 7'b1001111;
            4'd2:    seg = 7'b0010010;
            4'd3:    seg = 7'b0000110;
            4'd4:    seg = 7'b1001100;
            4'd5:    seg = 7'b0100100;
            4'd6:    seg = 7'b0100000;
            4'd7:    seg = 7'b0001111;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0000100;
`ifdef DISPLAY_HEX_DECODE_EN
            4'd10:   seg = 7'b0001000;
            4'd11:   seg = 7'b1100000;
            4'd12:   seg = 7'b0110001;
            4'd13:   seg = 7'b1000010;
            4'd14:   seg = 7'b0110000;
            4'd15:   seg = 7'b0111000;
`endif
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/display_scan_driver_scan_timer.sv
// Slot timer for the display scan: slot counter, digit index, frame-start strobe
// and the BLANK/SHOW state machine.
module scan_timer
    import display_pkg::*;
#(
    parameter int SLOT_CYCLES  = 100_000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic       clock,
    input  logic       reset,
    output logic [2:0] idx,
    output logic       show,
    output logic       show_next,
    output logic       frame_start
);

    localparam int CNT_W = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST_SLOT  = CNT_W'(SLOT_CYCLES - 1);
    localparam logic [CNT_W-1:0] LAST_BLANK = CNT_W'(BLANK_CYCLES - 1);

    logic [CNT_W-1:0] slot_cnt;
    scan_state_t      state, state_next;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            slot_cnt <= '0;
            idx      <= '0;
            state    <= ST_BLANK;
        end else begin
            state <= state_next;
            if (slot_cnt == LAST_SLOT) begin
                slot_cnt <= '0;
                idx      <= idx + 3'd1;
            end else begin
                slot_cnt <= slot_cnt + 1'b1;
            end
        end
    end

    // NOTE: next-state gets its default first so no path through the case infers a latch.
    always_comb begin
        state_next = state;
        case (state)
            ST_BLANK: if (slot_cnt == LAST_BLANK) state_next = ST_SHOW;
            ST_SHOW:  if (slot_cnt == LAST_SLOT)  state_next = ST_BLANK;
            default:  state_next = ST_BLANK;
        endcase
    end

    assign show        = (state == ST_SHOW);
    assign show_next   = (state_next == ST_SHOW);
    assign frame_start = (slot_cnt == '0) && (idx == 3'd0);

endmodule

// File: rtl/display_scan_driver.sv
// Time-multiplexed 8-digit common-anode seven-segment driver with per-frame input snapshot.
// Define DISPLAY_HEX_DECODE_EN to show values 10..15 as A..F instead of blank.
module display_scan_driver
    import display_pkg::*;
#(
    parameter int CLK_FREQ_HZ  = 100_000_000,
    parameter int SLOT_HZ      = 1000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [5:0] d1,
    input  logic [5:0] d2,
    input  logic [5:0] d3,
    input  logic [5:0] d4,
    input  logic [5:0] d5,
    input  logic [5:0] d6,
    input  logic [5:0] d7,
    input  logic [5:0] d8,
    output logic [7:0] an,
    output logic [7:0] dec_ddp
);

    localparam int SLOT_CYCLES = CLK_FREQ_HZ / SLOT_HZ;

    logic [2:0]  idx;
    logic        show, show_next, frame_start;
    digit_word_t d_in [8];
    digit_word_t snap [8];
    digit_word_t cur;
    logic [7:0]  an_show, dec_show;

    scan_timer #(
        .SLOT_CYCLES  (SLOT_CYCLES),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) u_timer (
        .clock       (clock),
        .reset       (reset),
        .idx         (idx),
        .show        (show),
        .show_next   (show_next),
        .frame_start (frame_start)
    );

    assign d_in[0] = d1;
    assign d_in[1] = d2;
    assign d_in[2] = d3;
    assign d_in[3] = d4;
    assign d_in[4] = d5;
    assign d_in[5] = d6;
    assign d_in[6] = d7;
    assign d_in[7] = d8;

    // NOTE: the snapshot is reset on purpose; a frame started right after reset must show known words.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 8; i++) snap[i] <= '0;
        end else if (frame_start) begin
            for (int i = 0; i < 8; i++) snap[i] <= d_in[i];
        end
    end

    // Bypass the snapshot on its load edge so a one-cycle blank still shows the fresh word.
    always_comb begin
        cur      = frame_start ? d_in[idx] : snap[idx];
        an_show  = cur.en ? ~(8'd1 << idx) : 8'hFF;
        dec_show = {seg7_decode(cur.value), cur.dp};
    end

    // Outputs load only on BLANK/SHOW transitions and hold for the rest of the phase.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            an      <= 8'hFF;
            dec_ddp <= 8'hFF;
        end else if (show_next && !show) begin
            an      <= an_show;
            dec_ddp <= dec_show;
        end else if (!show_next && show) begin
            an      <= 8'hFF;
            dec_ddp <= 8'hFF;
        end
    end

endmodule

// File: tb/tb_display_scan_driver.sv
// Self-checking bench for display_scan_driver: spec vectors, corner sequences, random frames vs model.
module tb_display_scan_driver;

    localparam int CLK      = 1000;
    localparam int SLOT     = 100;
    localparam int BLANK    = 2;
    localparam int SLOT_CYC = CLK / SLOT;
    localparam int FRAME    = 8 * SLOT_CYC;

`ifdef DISPLAY_HEX_DECODE_EN
    localparam logic [6:0] SEG_TBL [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100, 7'b0100100,
        7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
    localparam logic [7:0] HEX_A_DEC = 8'h11;
`else
    localparam logic [6:0] SEG_TBL [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100, 7'b0100100,
        7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100, 7'b1111111, 7'b1111111,
        7'b1111111, 7'b1111111, 7'b1111111, 7'b1111111};
    localparam logic [7:0] HEX_A_DEC = 8'hFF;
`endif

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [5:0] d [8];
    logic [7:0] an, dec_ddp;

    int n_checks = 0;
    int n_fail   = 0;

    display_scan_driver #(
        .CLK_FREQ_HZ  (CLK),
        .SLOT_HZ      (SLOT),
        .BLANK_CYCLES (BLANK)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .d1      (d[0]),
        .d2      (d[1]),
        .d3      (d[2]),
        .d4      (d[3]),
        .d5      (d[4]),
        .d6      (d[5]),
        .d7      (d[6]),
        .d8      (d[7]),
        .an      (an),
        .dec_ddp (dec_ddp)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: t = clock edges since reset release; snapshot taken at frame starts.
    int         t = 0;
    logic [5:0] msnap [8];

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            t = 0;
            for (int i = 0; i < 8; i++) msnap[i] = 6'd0;
        end else begin
            if (t % FRAME == 0) msnap = d;
            t++;
        end
    end

    function automatic logic [15:0] ref_out(input int tc);
        int         sc, ix;
        logic [5:0] w;
        logic [7:0] a;
        sc = tc % SLOT_CYC;
        ix = (tc / SLOT_CYC) % 8;
        if (sc < BLANK) return 16'hFFFF;
        w = msnap[ix];
        a = w[5] ? ~(8'd1 << ix) : 8'hFF;
        return {a, SEG_TBL[w[4:1]], w[0]};
    endfunction

    // Continuous monitor: model comparison, one-hot anodes, blank gap between different digits.
    logic [7:0] last_act  = 8'hFF;
    int         blank_run = 0;

    always @(negedge clock) begin
        logic [15:0] e;
        if (!reset) begin
            check("reset_an", an, 8'hFF);
            check("reset_dec", dec_ddp, 8'hFF);
            last_act  = 8'hFF;
            blank_run = 0;
        end else begin
            e = ref_out(t);
            check("model_an", an, e[15:8]);
            check("model_dec", dec_ddp, e[7:0]);
            check("onehot_an", 8'($countones(~an) <= 1), 8'd1);
            if (an == 8'hFF) begin
                blank_run++;
            end else begin
                if (last_act != 8'hFF && an != last_act)
                    check("blank_gap", 8'(blank_run >= BLANK), 8'd1);
                last_act  = an;
                blank_run = 0;
            end
        end
    end

    task automatic apply_reset(input logic [47:0] dw);
        @(posedge clock);
        #1 reset = 1'b0;
        for (int i = 0; i < 8; i++) d[i] = dw[6*i +: 6];
        @(posedge clock);
        #1 reset = 1'b1;
    endtask

    // Advance to the negedge sample point of cycle k; an overrun bound counts as a failure.
    task automatic wait_cycle(input int k);
        int guard;
        guard = 0;
        @(negedge clock);
        while (t < k && guard < 2000) begin
            @(negedge clock);
            guard++;
        end
        if (t != k) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_cycle: reached %0d, wanted %0d", t, k);
        end
    endtask

    typedef struct {
        string       name;
        logic [47:0] dw;
        int          cyc;
        logic [7:0]  an_exp;
        logic [7:0]  dec_exp;
    } vec_t;

    vec_t vecs[$];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [47:0] all8, mixed, hexa;
        all8  = {8{6'h31}};
        mixed = {36'h0, 6'h20, 6'h2B};
        hexa  = {42'h0, 6'h35};
        for (int i = 0; i < 8; i++) d[i] = 6'd0;

        vecs.push_back('{"all8_c0",   all8, 0,  8'hFF, 8'hFF});
        vecs.push_back('{"all8_c1",   all8, 1,  8'hFF, 8'hFF});
        vecs.push_back('{"all8_c2",   all8, 2,  8'hFE, 8'h01});
        vecs.push_back('{"all8_c9",   all8, 9,  8'hFE, 8'h01});
        vecs.push_back('{"all8_c10",  all8, 10, 8'hFF, 8'hFF});
        vecs.push_back('{"all8_c12",  all8, 12, 8'hFD, 8'h01});
        vecs.push_back('{"all8_c19",  all8, 19, 8'hFD, 8'h01});
        vecs.push_back('{"all8_c72",  all8, 72, 8'h7F, 8'h01});
        vecs.push_back('{"all8_c80",  all8, 80, 8'hFF, 8'hFF});
        vecs.push_back('{"all8_c82",  all8, 82, 8'hFE, 8'h01});
        vecs.push_back('{"mixed_s0",  mixed, 5,  8'hFE, 8'h49});
        vecs.push_back('{"mixed_s1",  mixed, 15, 8'hFD, 8'h02});
        vecs.push_back('{"mixed_s2",  mixed, 25, 8'hFF, 8'h02});
        vecs.push_back('{"mixed_s7",  mixed, 79, 8'hFF, 8'h02});
        vecs.push_back('{"hex_a",     hexa,  5,  8'hFE, HEX_A_DEC});

        for (int i = 0; i < vecs.size(); i++) begin
            if (i == 0 || vecs[i].dw != vecs[i-1].dw || vecs[i].cyc <= t)
                apply_reset(vecs[i].dw);
            wait_cycle(vecs[i].cyc);
            check({vecs[i].name, "_an"}, an, vecs[i].an_exp);
            check({vecs[i].name, "_dec"}, dec_ddp, vecs[i].dec_exp);
        end

        // d1 changes 3 -> 7 in slot 4; the new value appears only in the next frame.
        apply_reset({42'h0, 6'h27});
        wait_cycle(5);
        check("snap_old_an", an, 8'hFE);
        check("snap_old_dec", dec_ddp, 8'h0D);
        wait_cycle(45);
        #1 d[0] = 6'h2F;
        wait_cycle(81);
        check("snap_gap_dec", dec_ddp, 8'hFF);
        wait_cycle(82);
        check("snap_new_an", an, 8'hFE);
        check("snap_new_dec", dec_ddp, 8'h1F);

        // Asynchronous reset in the middle of idx 5's SHOW phase.
        apply_reset(all8);
        wait_cycle(55);
        check("pre_rst_an", an, 8'hDF);
        #2 reset = 1'b0;
        #1;
        check("async_rst_an", an, 8'hFF);
        check("async_rst_dec", dec_ddp, 8'hFF);
        for (int i = 0; i < 8; i++) d[i] = 6'h23;
        @(posedge clock);
        #1 reset = 1'b1;
        wait_cycle(2);
        check("post_rst_an", an, 8'hFE);
        check("post_rst_dec", dec_ddp, 8'h9F);

        // Random words changing at arbitrary points across ten frames; the monitor checks them.
        apply_reset({$urandom, $urandom} & 48'hFFFF_FFFF_FFFF);
        for (int c = 0; c < 10 * FRAME; c++) begin
            @(negedge clock);
            #1;
            if ($urandom_range(7) == 0) d[$urandom_range(7)] = 6'($urandom);
        end
        @(negedge clock);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
